vending_controller: RTL and testbench
=====================================

VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameter CARTEIRA_W, default 16, is the width of the accumulated-revenue register.
REQ-002 clock  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-high reset; the name is retained from existing ports, but the polarity is high.
REQ-004 escolher  input  2  product-select command; any nonzero value is a request.
REQ-005 inserir_dinheiro  input  2  money-insert command; any nonzero value is a request.
REQ-006 dar_troco  input  2  vend/change command; any nonzero value is a request.
REQ-007 produto_escolhido  input  8  product code; codes 1..4 are valid.
REQ-008 dinheiro_inserido  input  8  declared inserted amount, in centavos.
REQ-009 moedas_inseridas_25/_50/_100  input  8 each  inserted coin counts per denomination.
REQ-010 produto_liberado  output  1  one-cycle vend pulse.
REQ-011 produto_id  output  8  product code latched at selection.
REQ-012 moeda_troco_valid  output  1  one-cycle pulse per change coin.
REQ-013 moeda_troco_valor  output  8  value of that change coin: 25, 50 or 100.
REQ-014 carteira  output  CARTEIRA_W  accumulated revenue, in centavos.
REQ-015 erro  output  1  one-cycle error pulse.
REQ-016 estado  output  3  current FSM state encoding.

Function
REQ-017 A command event shall fire on a rising edge where the command is nonzero and its registered previous sample is zero; held levels shall not re-trigger.
REQ-018 The FSM shall have four states: IDLE, SELECTED, PAID and CHANGE; events not listed for a state shall be ignored.
REQ-019 In IDLE, an escolher event with code 1..4 shall latch produto_id and its price (1=50, 2=75, 3=100, 4=125) and move to SELECTED on the same edge.
REQ-020 In IDLE, an escolher event with code 0 or >4 shall pulse erro and remain in IDLE.
REQ-021 In SELECTED, an inserir_dinheiro event shall compute soma = 25*c25 + 50*c50 + 100*c100 with at least 16-bit arithmetic.
REQ-022 If soma differs from dinheiro_inserido, the block shall pulse erro, credit nothing and return to IDLE.
REQ-023 If soma is below the price, the block shall pulse erro and enter CHANGE with remainder = soma (full refund, no vend).
REQ-024 Otherwise, the block shall latch credito = soma and move to PAID.
REQ-025 In PAID, a dar_troco event shall pulse produto_liberado, add the price to carteira (saturating at all-ones), set remainder = credito - price and enter CHANGE.
REQ-026 In CHANGE, each cycle with remainder > 0 shall emit one coin, choosing greedily the largest of 100/50/25 that is <= remainder, and subtract it.
REQ-027 In CHANGE, when remainder = 0 the block shall return to IDLE on that edge; zero change shall emit no coin.
REQ-028 Simultaneous events shall be resolved by the current state only; in IDLE, escolher shall take priority.
REQ-029 Edge-detect samples shall update in every state, so commands asserted during CHANGE shall be consumed and lost.

Reset
REQ-030 While reset_n=1, on a clock edge all outputs shall be 0, the state shall be IDLE, and carteira, credito, remainder and all previous command samples shall be 0.
REQ-031 A reset asserted mid-CHANGE shall abort the operation, with no further coins emitted.

Structure
REQ-032 Package vending_pkg shall hold the state enum, the price table, the coin value constants (25/50/100) and the product-code range.
REQ-033 Sub-module troco_dispenser shall own the remainder register and the greedy coin emission; the top level shall keep the FSM, edge detection, validation and carteira.

Verification
REQ-034 Select 1; insert 150 as c50=1, c100=1; dar_troco -> produto_liberado=1; carteira=50; exactly one coin of 100.
REQ-035 Continue: select 2; insert 100 as c25=2, c50=1; dar_troco -> carteira=125; exactly one coin of 25.
REQ-036 Select 4; insert 250 as c100=2, c50=1; dar_troco -> coins 100, 25 in that order; carteira increases by 125.
REQ-037 Select 1; declare dinheiro_inserido=100 with c25=1 -> erro pulse; IDLE; no coins; carteira unchanged.
REQ-038 Select 3; insert 75 (c25=1, c50=1) -> erro pulse; coins 50 then 25; no produto_liberado.
REQ-039 Hold escolher=1 for 5 cycles -> exactly one selection; reset_n=1 during CHANGE -> no coin on any following cycle.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// coin denominations, valid product-code range and the price table.
package vending_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECTED = 3'd1,
        PAID     = 3'd2,
        CHANGE   = 3'd3
    } state_t;

    // Internal money arithmetic width; wide enough for 255 coins of each denomination.
    localparam int VALOR_W = 16;

    localparam logic [7:0] MOEDA_25  = 8'd25;
    localparam logic [7:0] MOEDA_50  = 8'd50;
    localparam logic [7:0] MOEDA_100 = 8'd100;

    localparam logic [7:0] PROD_MIN = 8'd1;
    localparam logic [7:0] PROD_MAX = 8'd4;

    function automatic logic codigo_valido(input logic [7:0] codigo);
        return (codigo >= PROD_MIN) && (codigo <= PROD_MAX);
    endfunction

    // Price in centavos; unknown codes map to 0 and are rejected before use.
    function automatic logic [7:0] preco_de(input logic [7:0] codigo);
        case (codigo)
            8'd1:    return 8'd50;
            8'd2:    return 8'd75;
            8'd3:    return 8'd100;
            8'd4:    return 8'd125;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/troco_dispenser.sv
// Change dispenser: holds the amount still owed and pays it out one coin
// per cycle, always choosing the largest denomination that fits.
module troco_dispenser
    import vending_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               carregar,
    input  logic [VALOR_W-1:0] valor_carga,
    input  logic               ativo,
    output logic [VALOR_W-1:0] restante,
    output logic               moeda_valid,
    output logic [7:0]         moeda_valor
);

    logic [7:0] moeda_sel;

    // Greedy denomination choice for the current remainder.
    always_comb begin
        moeda_sel = 8'd0;
        if (restante >= VALOR_W'(MOEDA_100))
            moeda_sel = MOEDA_100;
        else if (restante >= VALOR_W'(MOEDA_50))
            moeda_sel = MOEDA_50;
        else if (restante >= VALOR_W'(MOEDA_25))
            moeda_sel = MOEDA_25;
    end

    // Remainder register and one-cycle coin pulse; a sub-25 residue cannot be
    // paid and is dropped so the FSM can never stall in CHANGE.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            restante    <= '0;
            moeda_valid <= 1'b0;
            moeda_valor <= 8'd0;
        end else begin
            moeda_valid <= 1'b0;
            moeda_valor <= 8'd0;
            if (carregar) begin
                restante <= valor_carga;
            end else if (ativo && (restante != '0)) begin
                if (moeda_sel != 8'd0) begin
                    moeda_valid <= 1'b1;
                    moeda_valor <= moeda_sel;
                    restante    <= restante - VALOR_W'(moeda_sel);
                end else begin
                    restante <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/vending_controller.sv
// Vending controller top: command edge detection, selection/payment
// validation, revenue accumulation and the IDLE/SELECTED/PAID/CHANGE FSM.
// Change payout is delegated to troco_dispenser.
module vending_controller
    import vending_pkg::*;
#(
    parameter int CARTEIRA_W = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            escolher,
    input  logic [1:0]            inserir_dinheiro,
    input  logic [1:0]            dar_troco,
    input  logic [7:0]            produto_escolhido,
    input  logic [7:0]            dinheiro_inserido,
    input  logic [7:0]            moedas_inseridas_25,
    input  logic [7:0]            moedas_inseridas_50,
    input  logic [7:0]            moedas_inseridas_100,
    output logic                  produto_liberado,
    output logic [7:0]            produto_id,
    output logic                  moeda_troco_valid,
    output logic [7:0]            moeda_troco_valor,
    output logic [CARTEIRA_W-1:0] carteira,
    output logic                  erro,
    output logic [2:0]            estado
);

    state_t estado_q, estado_d;

    logic [1:0] escolher_prev, inserir_prev, troco_prev;
    logic       ev_escolher, ev_inserir, ev_troco;

    logic [7:0]         preco_q;
    logic [VALOR_W-1:0] credito_q;
    logic [VALOR_W-1:0] soma;
    logic               soma_confere, soma_cobre;

    logic               erro_d, liberar_d, latch_sel, latch_credito, somar_carteira;
    logic               carga;
    logic [VALOR_W-1:0] carga_valor;
    logic [VALOR_W-1:0] restante;

    // Revenue accumulation clamps at all-ones instead of wrapping.
    function automatic logic [CARTEIRA_W-1:0] soma_saturada(
        input logic [CARTEIRA_W-1:0] a,
        input logic [7:0]            p
    );
        logic [CARTEIRA_W:0] s;
        s = {1'b0, a} + (CARTEIRA_W+1)'(p);
        if (s[CARTEIRA_W])
            return '1;
        return s[CARTEIRA_W-1:0];
    endfunction

    assign ev_escolher = (escolher != 2'd0)         && (escolher_prev == 2'd0);
    assign ev_inserir  = (inserir_dinheiro != 2'd0) && (inserir_prev == 2'd0);
    assign ev_troco    = (dar_troco != 2'd0)        && (troco_prev == 2'd0);

    assign soma = VALOR_W'(moedas_inseridas_25)  * VALOR_W'(MOEDA_25)
                + VALOR_W'(moedas_inseridas_50)  * VALOR_W'(MOEDA_50)
                + VALOR_W'(moedas_inseridas_100) * VALOR_W'(MOEDA_100);

    assign soma_confere = (soma == VALOR_W'(dinheiro_inserido));
    assign soma_cobre   = (soma >= VALOR_W'(preco_q));

    assign estado = estado_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset_n)
            estado_q <= IDLE;
        else
            estado_q <= estado_d;
    end

    // Next-state logic; each state reacts only to its own command.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE: begin
                if (ev_escolher && codigo_valido(produto_escolhido))
                    estado_d = SELECTED;
            end
            SELECTED: begin
                if (ev_inserir) begin
                    if (!soma_confere)
                        estado_d = IDLE;
                    else if (!soma_cobre)
                        estado_d = CHANGE;
                    else
                        estado_d = PAID;
                end
            end
            PAID: begin
                if (ev_troco)
                    estado_d = CHANGE;
            end
            CHANGE: begin
                if (restante == '0)
                    estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    // Action decode: pulses, latch enables and dispenser load for this edge.
    always_comb begin
        erro_d         = 1'b0;
        liberar_d      = 1'b0;
        latch_sel      = 1'b0;
        latch_credito  = 1'b0;
        somar_carteira = 1'b0;
        carga          = 1'b0;
        carga_valor    = '0;
        case (estado_q)
            IDLE: begin
                if (ev_escolher) begin
                    if (codigo_valido(produto_escolhido))
                        latch_sel = 1'b1;
                    else
                        erro_d = 1'b1;
                end
            end
            SELECTED: begin
                if (ev_inserir) begin
                    if (!soma_confere) begin
                        erro_d = 1'b1;
                    end else if (!soma_cobre) begin
                        erro_d      = 1'b1;
                        carga       = 1'b1;
                        carga_valor = soma;
                    end else begin
                        latch_credito = 1'b1;
                    end
                end
            end
            PAID: begin
                if (ev_troco) begin
                    liberar_d      = 1'b1;
                    somar_carteira = 1'b1;
                    carga          = 1'b1;
                    carga_valor    = credito_q - VALOR_W'(preco_q);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, edge-detect history and registered output pulses.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            escolher_prev    <= 2'd0;
            inserir_prev     <= 2'd0;
            troco_prev       <= 2'd0;
            produto_id       <= 8'd0;
            preco_q          <= 8'd0;
            credito_q        <= '0;
            carteira         <= '0;
            erro             <= 1'b0;
            produto_liberado <= 1'b0;
        end else begin
            escolher_prev    <= escolher;
            inserir_prev     <= inserir_dinheiro;
            troco_prev       <= dar_troco;
            erro             <= erro_d;
            produto_liberado <= liberar_d;
            if (latch_sel) begin
                produto_id <= produto_escolhido;
                preco_q    <= preco_de(produto_escolhido);
            end
            if (latch_credito)
                credito_q <= soma;
            if (somar_carteira)
                carteira <= soma_saturada(carteira, preco_q);
        end
    end

    troco_dispenser u_troco (
        .clock       (clock),
        .reset_n     (reset_n),
        .carregar    (carga),
        .valor_carga (carga_valor),
        .ativo       (estado_q == CHANGE),
        .restante    (restante),
        .moeda_valid (moeda_troco_valid),
        .moeda_valor (moeda_troco_valor)
    );

endmodule

// File: tb/tb_vending_controller.sv
// Scenario bench for vending_controller: expected change coins are queued
// when a transaction is driven and checked by a monitor as they appear.
module tb_vending_controller;

    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic [1:0]    escolher = '0, inserir_dinheiro = '0, dar_troco = '0;
    logic [7:0]    produto_escolhido = '0, dinheiro_inserido = '0;
    logic [7:0]    moedas_inseridas_25 = '0, moedas_inseridas_50 = '0, moedas_inseridas_100 = '0;
    logic          produto_liberado, moeda_troco_valid, erro;
    logic [7:0]    produto_id, moeda_troco_valor;
    logic [CW-1:0] carteira;
    logic [2:0]    estado;

    int n_cmp = 0;
    int n_err = 0;
    int coins_seen = 0;
    int liberados = 0;
    int erros = 0;
    int exp_cart = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e_coin;

    vending_controller #(.CARTEIRA_W(CW)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .escolher             (escolher),
        .inserir_dinheiro     (inserir_dinheiro),
        .dar_troco            (dar_troco),
        .produto_escolhido    (produto_escolhido),
        .dinheiro_inserido    (dinheiro_inserido),
        .moedas_inseridas_25  (moedas_inseridas_25),
        .moedas_inseridas_50  (moedas_inseridas_50),
        .moedas_inseridas_100 (moedas_inseridas_100),
        .produto_liberado     (produto_liberado),
        .produto_id           (produto_id),
        .moeda_troco_valid    (moeda_troco_valid),
        .moeda_troco_valor    (moeda_troco_valor),
        .carteira             (carteira),
        .erro                 (erro),
        .estado               (estado)
    );

    always #5 clock = ~clock;

    // Monitor: pop the scoreboard on every change coin, count pulses.
    always @(negedge clock) begin
        if (moeda_troco_valid === 1'b1) begin
            coins_seen++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL coin_unexpected: got valor=%0d, required no coin", moeda_troco_valor);
            end else begin
                e_coin = exp_q.pop_front();
                if (moeda_troco_valor !== e_coin) begin
                    n_err++;
                    $display("FAIL coin_value: got %0d, required %0d", moeda_troco_valor, e_coin);
                end
            end
        end
        if (produto_liberado === 1'b1) liberados++;
        if (erro === 1'b1) erros++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_select(input logic [1:0] cmd, input logic [7:0] code);
        @(negedge clock);
        escolher = cmd;
        produto_escolhido = code;
        @(negedge clock);
        escolher = 2'd0;
        @(negedge clock);
    endtask

    task automatic do_insert(input logic [7:0] c25, input logic [7:0] c50,
                             input logic [7:0] c100, input logic [7:0] decl);
        @(negedge clock);
        moedas_inseridas_25 = c25;
        moedas_inseridas_50 = c50;
        moedas_inseridas_100 = c100;
        dinheiro_inserido = decl;
        inserir_dinheiro = 2'd1;
        @(negedge clock);
        inserir_dinheiro = 2'd0;
        @(negedge clock);
    endtask

    task automatic do_vend();
        @(negedge clock);
        dar_troco = 2'd2;
        @(negedge clock);
        dar_troco = 2'd0;
        @(negedge clock);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            if (estado === 3'd0) done = 1;
            else @(negedge clock);
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_idle_timeout: estado=%0d, required 0", name, estado);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        cycles(3);
        n_cmp++;
        if ({estado, carteira, produto_id, erro, produto_liberado, moeda_troco_valid, moeda_troco_valor}
            !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: estado=%0d carteira=%0d id=%0d erro=%b lib=%b mv=%b mval=%0d, required all 0",
                     estado, carteira, produto_id, erro, produto_liberado, moeda_troco_valid, moeda_troco_valor);
        end
        reset_n = 1'b0;
        cycles(2);
        exp_cart = 0;
    endtask

    task automatic test_vend(input string name, input logic [7:0] code,
                             input logic [7:0] c25, input logic [7:0] c50, input logic [7:0] c100,
                             input logic [7:0] decl, input int price);
        int lib0, coin0, rem;
        lib0 = liberados;
        coin0 = coins_seen;
        do_select(2'd1, code);
        n_cmp++;
        if (estado !== 3'd1 || produto_id !== code) begin
            n_err++;
            $display("FAIL %s_select: estado=%0d id=%0d, required 1 and %0d", name, estado, produto_id, code);
        end
        do_insert(c25, c50, c100, decl);
        n_cmp++;
        if (estado !== 3'd2) begin
            n_err++;
            $display("FAIL %s_paid: estado=%0d, required 2", name, estado);
        end
        // Greedy change model for the expected coin sequence.
        rem = int'(decl) - price;
        while (rem >= 100) begin exp_q.push_back(8'd100); rem -= 100; end
        while (rem >= 50)  begin exp_q.push_back(8'd50);  rem -= 50;  end
        while (rem >= 25)  begin exp_q.push_back(8'd25);  rem -= 25;  end
        exp_cart = (exp_cart + price > 65535) ? 65535 : exp_cart + price;
        do_vend();
        wait_idle(name);
        n_cmp++;
        if (liberados - lib0 !== 1) begin
            n_err++;
            $display("FAIL %s_liberado: got %0d pulses, required 1", name, liberados - lib0);
        end
        n_cmp++;
        if (int'(carteira) !== exp_cart) begin
            n_err++;
            $display("FAIL %s_carteira: got %0d, required %0d", name, carteira, exp_cart);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_coins_missing: %0d coins not emitted (seen %0d)", name, exp_q.size(), coins_seen - coin0);
            exp_q.delete();
        end
    endtask

    task automatic test_mismatch();
        int e0, c0;
        e0 = erros;
        c0 = coins_seen;
        do_select(2'd1, 8'd1);
        do_insert(8'd1, 8'd0, 8'd0, 8'd100);
        n_cmp++;
        if (erros - e0 !== 1 || estado !== 3'd0) begin
            n_err++;
            $display("FAIL mismatch_erro: erro pulses=%0d estado=%0d, required 1 and 0", erros - e0, estado);
        end
        cycles(4);
        n_cmp++;
        if (coins_seen !== c0 || int'(carteira) !== exp_cart) begin
            n_err++;
            $display("FAIL mismatch_effects: coins=%0d carteira=%0d, required 0 and %0d",
                     coins_seen - c0, carteira, exp_cart);
        end
    endtask

    task automatic test_underpay();
        int e0, l0;
        e0 = erros;
        l0 = liberados;
        do_select(2'd3, 8'd3);
        exp_q.push_back(8'd50);
        exp_q.push_back(8'd25);
        do_insert(8'd1, 8'd1, 8'd0, 8'd75);
        wait_idle("underpay");
        n_cmp++;
        if (erros - e0 !== 1 || liberados !== l0) begin
            n_err++;
            $display("FAIL underpay_pulses: erro=%0d liberado=%0d, required 1 and 0", erros - e0, liberados - l0);
        end
        n_cmp++;
        if (exp_q.size() != 0 || int'(carteira) !== exp_cart) begin
            n_err++;
            $display("FAIL underpay_refund: pending coins=%0d carteira=%0d, required 0 and %0d",
                     exp_q.size(), carteira, exp_cart);
            exp_q.delete();
        end
    endtask

    task automatic test_invalid_select();
        int e0;
        e0 = erros;
        do_select(2'd1, 8'd0);
        do_select(2'd2, 8'd7);
        n_cmp++;
        if (erros - e0 !== 2 || estado !== 3'd0) begin
            n_err++;
            $display("FAIL invalid_select: erro pulses=%0d estado=%0d, required 2 and 0", erros - e0, estado);
        end
    endtask

    task automatic test_held_and_reset();
        int e0, c0;
        e0 = erros;
        @(negedge clock);
        escolher = 2'd1;
        produto_escolhido = 8'd2;
        cycles(5);
        escolher = 2'd0;
        @(negedge clock);
        n_cmp++;
        if (estado !== 3'd1 || produto_id !== 8'd2 || erros !== e0) begin
            n_err++;
            $display("FAIL held_select: estado=%0d id=%0d erro=%0d, required 1, 2, 0", estado, produto_id, erros - e0);
        end
        do_insert(8'd0, 8'd0, 8'd2, 8'd200);
        c0 = coins_seen;
        exp_q.push_back(8'd100);
        do_vend();
        // First coin (100) is out now; abort the remaining 25 with reset.
        reset_n = 1'b1;
        cycles(2);
        n_cmp++;
        if (estado !== 3'd0 || carteira !== '0 || moeda_troco_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_change: estado=%0d carteira=%0d mv=%b, required 0, 0, 0",
                     estado, carteira, moeda_troco_valid);
        end
        reset_n = 1'b0;
        exp_cart = 0;
        cycles(10);
        n_cmp++;
        if (coins_seen - c0 !== 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_abort_coins: got %0d coins, required 1", coins_seen - c0);
            exp_q.delete();
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 530; i++) begin
            do_select(2'd1, 8'd4);
            do_insert(8'd1, 8'd0, 8'd1, 8'd125);
            do_vend();
            wait_idle("sat");
            exp_cart = (exp_cart + 125 > 65535) ? 65535 : exp_cart + 125;
        end
        n_cmp++;
        if (int'(carteira) !== exp_cart) begin
            n_err++;
            $display("FAIL carteira_saturation: got %0d, required %0d", carteira, exp_cart);
        end
    endtask

    initial begin
        test_reset();
        test_vend("vend_p1", 8'd1, 8'd0, 8'd1, 8'd1, 8'd150, 50);
        test_vend("vend_p2", 8'd2, 8'd2, 8'd1, 8'd0, 8'd100, 75);
        test_vend("vend_p4", 8'd4, 8'd0, 8'd1, 8'd2, 8'd250, 125);
        test_mismatch();
        test_underpay();
        test_invalid_select();
        test_held_and_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
